// File: rtl/board_io_pkg.sv
// ---------------------------------------------------------------------------
// board_io_pkg
// Shared types, widths and helpers for the board I/O controller.
//   PWM_W            width of the LED brightness counter and duty input
//   gpio_mode_t      per-pin drive mode (push-pull or open-drain)
//   debounce_cnt_w() width of a debounce counter able to hold 'cycles'
// ---------------------------------------------------------------------------
package board_io_pkg;

  localparam int PWM_W = 8;

  typedef enum logic {
    GPIO_PUSH_PULL  = 1'b0,
    GPIO_OPEN_DRAIN = 1'b1
  } gpio_mode_t;

  // Counter width that can represent the value 'cycles'; never below one bit
  // so a degenerate parameter still yields a legal vector.
  function automatic int debounce_cnt_w(input int cycles);
    if (cycles < 1) begin
      return 1;
    end
    return $clog2(cycles + 1);
  endfunction

endpackage

// File: rtl/io_debounce.sv
// ---------------------------------------------------------------------------
// io_debounce
// One button channel: optional inversion, synchroniser chain, debounce
// counter, stable level register and single-cycle edge pulses.
// Ports:
//   clk_i    system clock
//   rst_i    synchronous active-high reset
//   btn_i    raw asynchronous button pad
//   level_o  debounced level
//   rise_o   one-cycle pulse in the cycle level_o becomes 1
//   fall_o   one-cycle pulse in the cycle level_o becomes 0
// SYNC_STAGES must be in 2..4, DEBOUNCE_CYCLES at least 1.
// ---------------------------------------------------------------------------
module io_debounce
  import board_io_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter bit ACTIVE_LOW      = 1'b0
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic btn_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  localparam int              CNT_W    = debounce_cnt_w(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   synced;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   level_q, level_d;
  logic                   rise_q, rise_d;
  logic                   fall_q, fall_d;

  assign synced  = sync_q[SYNC_STAGES-1];
  assign level_o = level_q;
  assign rise_o  = rise_q;
  assign fall_o  = fall_q;

  // Synchroniser chain; the polarity fix is applied before the first flop so
  // everything downstream works on "pressed = 1".
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], btn_i ^ ACTIVE_LOW};
    end
  end

  // Any cycle where the synced value matches the stable level restarts the
  // count, so only an uninterrupted run of DEBOUNCE_CYCLES differing cycles
  // flips the level. The edge pulses are registered alongside the level so
  // they coincide with the cycle the new level is visible.
  always_comb begin
    cnt_d   = '0;
    level_d = level_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    if (synced != level_q) begin
      if (cnt_q == CNT_LAST) begin
        level_d = synced;
        rise_d  = synced;
        fall_d  = ~synced;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q   <= '0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      level_q <= level_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

endmodule

// File: rtl/board_io_ctrl.sv
// ---------------------------------------------------------------------------
// board_io_ctrl
// Board-level pad controller between FPGA pads and the SoC.
// Ports:
//   sys_clk, sys_rst        clock, synchronous active-high reset
//   btn_i                   raw button pads
//   btn_level_o             debounced button levels
//   btn_rise_o/btn_fall_o   one-cycle edge pulses of the debounced levels
//   btn_event_o             sticky rise flags, cleared by btn_event_clr_i
//   gpio_out_i/dir_i/od_i   SoC-side GPIO value, drive enable, open-drain mode
//   gpio_in_o               synchronised pad readback
//   gpio_pad_i/_o/_oe       pad input, registered pad value and enable
//   led_val_i, led_duty_i   LED on requests and global PWM brightness
//   led_o                   registered LED pads
// All pad-facing outputs are flops so the board top only adds tristates.
// ---------------------------------------------------------------------------
module board_io_ctrl
  import board_io_pkg::*;
#(
  parameter int NUM_BTN         = 6,
  parameter int NUM_GPIO        = 2,
  parameter int NUM_LED         = 8,
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter bit BTN_ACTIVE_LOW  = 1'b0
) (
  input  logic                sys_clk,
  input  logic                sys_rst,
  input  logic [NUM_BTN-1:0]  btn_i,
  output logic [NUM_BTN-1:0]  btn_level_o,
  output logic [NUM_BTN-1:0]  btn_rise_o,
  output logic [NUM_BTN-1:0]  btn_fall_o,
  output logic [NUM_BTN-1:0]  btn_event_o,
  input  logic [NUM_BTN-1:0]  btn_event_clr_i,
  input  logic [NUM_GPIO-1:0] gpio_out_i,
  input  logic [NUM_GPIO-1:0] gpio_dir_i,
  input  logic [NUM_GPIO-1:0] gpio_od_i,
  output logic [NUM_GPIO-1:0] gpio_in_o,
  input  logic [NUM_GPIO-1:0] gpio_pad_i,
  output logic [NUM_GPIO-1:0] gpio_pad_o,
  output logic [NUM_GPIO-1:0] gpio_pad_oe,
  input  logic [NUM_LED-1:0]  led_val_i,
  input  logic [PWM_W-1:0]    led_duty_i,
  output logic [NUM_LED-1:0]  led_o
);

  // One conditioning channel per button.
  for (genvar g = 0; g < NUM_BTN; g++) begin : g_btn
    io_debounce #(
      .SYNC_STAGES     (SYNC_STAGES),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .ACTIVE_LOW      (BTN_ACTIVE_LOW)
    ) u_debounce (
      .clk_i   (sys_clk),
      .rst_i   (sys_rst),
      .btn_i   (btn_i[g]),
      .level_o (btn_level_o[g]),
      .rise_o  (btn_rise_o[g]),
      .fall_o  (btn_fall_o[g])
    );
  end

  logic [NUM_BTN-1:0]                  event_q, event_d;
  logic [NUM_GPIO-1:0]                 pad_q, pad_d;
  logic [NUM_GPIO-1:0]                 oe_q, oe_d;
  logic [SYNC_STAGES-1:0][NUM_GPIO-1:0] gpio_sync_q;
  logic [PWM_W-1:0]                    pwm_cnt_q, pwm_cnt_d;
  logic [NUM_LED-1:0]                  led_q, led_d;
  logic                                led_on;
  gpio_mode_t                          mode;

  assign btn_event_o = event_q;
  assign gpio_pad_o  = pad_q;
  assign gpio_pad_oe = oe_q;
  assign gpio_in_o   = gpio_sync_q[SYNC_STAGES-1];
  assign led_o       = led_q;

  // Sticky flags: a rise in the same cycle as a clear wins, so a press is
  // never lost to a software clear racing it.
  always_comb begin
    event_d = (event_q & ~btn_event_clr_i) | btn_rise_o;
  end

  // Open-drain pins never drive high: they release the pad (oe=0) for a 1
  // and pull it low for a 0, which is exactly the I2C wiring.
  always_comb begin
    pad_d = '0;
    oe_d  = '0;
    mode  = GPIO_PUSH_PULL;
    for (int i = 0; i < NUM_GPIO; i++) begin
      mode = gpio_mode_t'(gpio_od_i[i]);
      if (mode == GPIO_OPEN_DRAIN) begin
        pad_d[i] = 1'b0;
        oe_d[i]  = gpio_dir_i[i] & ~gpio_out_i[i];
      end else begin
        pad_d[i] = gpio_out_i[i];
        oe_d[i]  = gpio_dir_i[i];
      end
    end
  end

  // Full-scale duty is treated as always on; a plain compare would leave
  // one dark cycle in every 256.
  always_comb begin
    pwm_cnt_d = pwm_cnt_q + PWM_W'(1);
    led_on    = (pwm_cnt_q < led_duty_i) || (led_duty_i == {PWM_W{1'b1}});
    led_d     = led_val_i & {NUM_LED{led_on}};
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      event_q     <= '0;
      pad_q       <= '0;
      oe_q        <= '0;
      gpio_sync_q <= '0;
      pwm_cnt_q   <= '0;
      led_q       <= '0;
    end else begin
      event_q     <= event_d;
      pad_q       <= pad_d;
      oe_q        <= oe_d;
      gpio_sync_q <= {gpio_sync_q[SYNC_STAGES-2:0], gpio_pad_i};
      pwm_cnt_q   <= pwm_cnt_d;
      led_q       <= led_d;
    end
  end

endmodule

// File: tb/tb_board_io_ctrl.sv
// ---------------------------------------------------------------------------
// tb_board_io_ctrl
// Self-checking bench for board_io_ctrl with a short debounce window.
// Expected values go into a FIFO scoreboard when stimulus is applied and are
// popped when the corresponding DUT output is sampled (1 time unit after a
// rising edge).
// ---------------------------------------------------------------------------
module tb_board_io_ctrl;

  localparam int NUM_BTN         = 6;
  localparam int NUM_GPIO        = 2;
  localparam int NUM_LED         = 8;
  localparam int SYNC_STAGES     = 2;
  localparam int DEBOUNCE_CYCLES = 4;
  localparam int LATENCY         = SYNC_STAGES + DEBOUNCE_CYCLES;

  logic                sysClk = 1'b0;
  logic                sysRst;
  logic [NUM_BTN-1:0]  btnI;
  logic [NUM_BTN-1:0]  btnLevel, btnRise, btnFall, btnEvent;
  logic [NUM_BTN-1:0]  btnEventClr;
  logic [NUM_GPIO-1:0] gpioOut, gpioDir, gpioOd, gpioIn, gpioPadI, gpioPadO, gpioPadOe;
  logic [NUM_LED-1:0]  ledVal, ledO;
  logic [7:0]          ledDuty;

  board_io_ctrl #(
    .NUM_BTN         (NUM_BTN),
    .NUM_GPIO        (NUM_GPIO),
    .NUM_LED         (NUM_LED),
    .SYNC_STAGES     (SYNC_STAGES),
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .BTN_ACTIVE_LOW  (1'b0)
  ) dut (
    .sys_clk         (sysClk),
    .sys_rst         (sysRst),
    .btn_i           (btnI),
    .btn_level_o     (btnLevel),
    .btn_rise_o      (btnRise),
    .btn_fall_o      (btnFall),
    .btn_event_o     (btnEvent),
    .btn_event_clr_i (btnEventClr),
    .gpio_out_i      (gpioOut),
    .gpio_dir_i      (gpioDir),
    .gpio_od_i       (gpioOd),
    .gpio_in_o       (gpioIn),
    .gpio_pad_i      (gpioPadI),
    .gpio_pad_o      (gpioPadO),
    .gpio_pad_oe     (gpioPadOe),
    .led_val_i       (ledVal),
    .led_duty_i      (ledDuty),
    .led_o           (ledO)
  );

  // 100 MHz-style free-running clock.
  always #5 sysClk = ~sysClk;

  typedef struct {
    logic [NUM_GPIO-1:0] out;
    logic [NUM_GPIO-1:0] dir;
    logic [NUM_GPIO-1:0] od;
    logic [NUM_GPIO-1:0] padExp;
    logic [NUM_GPIO-1:0] oeExp;
  } gpioVec_t;

  typedef struct {
    logic [NUM_LED-1:0] val;
    logic [7:0]         duty;
    int                 highExp;
  } pwmVec_t;

  int          testsRun    = 0;
  int          testsFailed = 0;
  logic [31:0] expQ[$];
  logic [31:0] prevGpio    = '0;

  gpioVec_t gpioVecs[7];
  pwmVec_t  pwmVecs[5];

  // Advance n rising edges and settle just past the last one.
  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge sysClk);
      #1;
    end
  endtask

  task automatic expectValue(input logic [31:0] v);
    expQ.push_back(v);
  endtask

  // Pop the oldest expectation and compare it with what the DUT shows now.
  task automatic checkOutput(input string name, input logic [31:0] actual);
    logic [31:0] expv;
    testsRun++;
    if (expQ.size() == 0) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0h, scoreboard empty", name, actual);
    end else begin
      expv = expQ.pop_front();
      if (actual !== expv) begin
        testsFailed++;
        $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expv);
      end
    end
  endtask

  task automatic checkNow(input string name, input logic [31:0] actual, input logic [31:0] expv);
    expectValue(expv);
    checkOutput(name, actual);
  endtask

  // Drive one GPIO vector; the old pad state must still be visible before
  // the edge and the new one after it.
  task automatic applyStimulus(input gpioVec_t v);
    gpioOut = v.out;
    gpioDir = v.dir;
    gpioOd  = v.od;
    expectValue(prevGpio);
    expectValue(32'({v.padExp, v.oeExp}));
    prevGpio = 32'({v.padExp, v.oeExp});
  endtask

  task automatic applyPwmStimulus(input pwmVec_t v);
    ledVal  = v.val;
    ledDuty = v.duty;
    expectValue(32'(v.highExp));
  endtask

  // Hard stop in case the run never reaches its summary.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int         highs;
    logic [6:0] upperSeen;

    //                out    dir    od     pad    oe
    gpioVecs[0] = '{2'b11, 2'b11, 2'b00, 2'b11, 2'b11};
    gpioVecs[1] = '{2'b11, 2'b11, 2'b11, 2'b00, 2'b00};
    gpioVecs[2] = '{2'b00, 2'b11, 2'b11, 2'b00, 2'b11};
    gpioVecs[3] = '{2'b10, 2'b01, 2'b00, 2'b10, 2'b01};
    gpioVecs[4] = '{2'b01, 2'b11, 2'b10, 2'b01, 2'b11};
    gpioVecs[5] = '{2'b10, 2'b10, 2'b01, 2'b10, 2'b10};
    gpioVecs[6] = '{2'b00, 2'b00, 2'b00, 2'b00, 2'b00};

    //               val     duty    high cycles per 256
    pwmVecs[0] = '{8'h01, 8'd64,  64};
    pwmVecs[1] = '{8'h01, 8'd0,   0};
    pwmVecs[2] = '{8'h01, 8'hFF,  256};
    pwmVecs[3] = '{8'h01, 8'd128, 128};
    pwmVecs[4] = '{8'h00, 8'hFF,  0};

    sysRst      = 1'b1;
    btnI        = '0;
    btnEventClr = '0;
    gpioOut     = '0;
    gpioDir     = '0;
    gpioOd      = '0;
    gpioPadI    = 2'b11;
    ledVal      = '0;
    ledDuty     = '0;

    // Reset state: every output low, including the synchronised pad input.
    tick(3);
    checkNow("reset level", 32'(btnLevel), 0);
    checkNow("reset rise", 32'(btnRise), 0);
    checkNow("reset fall", 32'(btnFall), 0);
    checkNow("reset event", 32'(btnEvent), 0);
    checkNow("reset gpio_in", 32'(gpioIn), 0);
    checkNow("reset pad", 32'({gpioPadO, gpioPadOe}), 0);
    checkNow("reset led", 32'(ledO), 0);
    sysRst = 1'b0;
    tick(3);
    checkNow("gpio_in pulled up", 32'(gpioIn), 32'(2'b11));

    // Clean press on button 0, with a clear racing the rise pulse.
    btnI[0] = 1'b1;
    for (int k = 1; k <= LATENCY; k++) begin
      tick();
      checkNow("press level", 32'(btnLevel[0]), 32'(k == LATENCY));
      checkNow("press rise", 32'(btnRise[0]), 32'(k == LATENCY));
      checkNow("press event", 32'(btnEvent[0]), 0);
    end
    btnEventClr[0] = 1'b1;
    tick();
    checkNow("rise one cycle", 32'(btnRise[0]), 0);
    checkNow("set beats clear", 32'(btnEvent[0]), 1);
    tick();
    checkNow("clear alone", 32'(btnEvent[0]), 0);
    btnEventClr[0] = 1'b0;
    tick();
    checkNow("press level held", 32'(btnLevel), 32'(6'b000001));

    // Short glitch on button 1 must leave no trace.
    btnI[1] = 1'b1;
    for (int k = 1; k <= 13; k++) begin
      if (k == 4) btnI[1] = 1'b0;
      tick();
      checkNow("glitch quiet", 32'({btnLevel[1], btnRise[1], btnFall[1], btnEvent[1]}), 0);
    end

    // A five-cycle pulse is long enough: rise, then fall a full latency
    // after release.
    btnI[1] = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      tick();
      checkNow("pulse5 level pre", 32'(btnLevel[1]), 0);
    end
    btnI[1] = 1'b0;
    for (int k = 1; k <= LATENCY; k++) begin
      tick();
      checkNow("pulse5 level", 32'(btnLevel[1]), 32'(k < LATENCY));
      checkNow("pulse5 rise", 32'(btnRise[1]), 32'(k == 1));
      checkNow("pulse5 fall", 32'(btnFall[1]), 32'(k == LATENCY));
    end
    tick();
    checkNow("pulse5 fall one cycle", 32'(btnFall[1]), 0);
    checkNow("pulse5 event", 32'(btnEvent[1]), 1);

    // GPIO mode table.
    for (int i = 0; i < 7; i++) begin
      applyStimulus(gpioVecs[i]);
      #1;
      checkOutput("gpio before edge", 32'({gpioPadO, gpioPadOe}));
      tick();
      checkOutput("gpio after edge", 32'({gpioPadO, gpioPadOe}));
    end

    // Pad pulled low externally while released: two-edge readback.
    gpioPadI = 2'b10;
    tick();
    checkNow("gpio_in edge1", 32'(gpioIn), 32'(2'b11));
    tick();
    checkNow("gpio_in edge2", 32'(gpioIn), 32'(2'b10));

    // PWM: count high cycles over one full period per duty setting.
    for (int i = 0; i < 5; i++) begin
      applyPwmStimulus(pwmVecs[i]);
      tick();
      highs     = 0;
      upperSeen = '0;
      for (int c = 0; c < 256; c++) begin
        tick();
        highs     += int'(ledO[0]);
        upperSeen |= ledO[7:1];
      end
      checkOutput("pwm high count", 32'(highs));
      checkNow("pwm upper leds", 32'(upperSeen), 0);
    end

    // Reset partway through a press on button 2, with LEDs and pads active.
    ledVal  = 8'h01;
    ledDuty = 8'hFF;
    gpioOut = 2'b11;
    gpioDir = 2'b11;
    gpioOd  = 2'b00;
    tick(2);
    checkNow("pre-reset led", 32'(ledO), 32'(8'h01));
    btnI[2] = 1'b1;
    tick(3);
    sysRst = 1'b1;
    tick();
    checkNow("midrst level", 32'(btnLevel), 0);
    checkNow("midrst event", 32'(btnEvent), 0);
    checkNow("midrst gpio_in", 32'(gpioIn), 0);
    checkNow("midrst pad", 32'({gpioPadO, gpioPadOe}), 0);
    checkNow("midrst led", 32'(ledO), 0);
    sysRst = 1'b0;
    for (int k = 1; k <= LATENCY; k++) begin
      tick();
      checkNow("post-reset level", 32'(btnLevel), (k == LATENCY) ? 32'(6'b000101) : 32'(0));
      checkNow("post-reset rise", 32'(btnRise), (k == LATENCY) ? 32'(6'b000101) : 32'(0));
    end

    if (expQ.size() != 0) begin
      testsRun++;
      testsFailed++;
      $display("[TB] FAIL scoreboard leftover: got %0d entries, expected 0", expQ.size());
    end

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule

// File: doc/board_io_ctrl.md
# board_io_ctrl

Parametrised board-level I/O controller that sits between FPGA pads and the `soc`, one level below the board top. It generalises the pad handling the top level currently does inline:
- N-channel button conditioning (synchroniser, debounce, edge events, sticky flags).
- N-channel GPIO pads with per-pin push-pull or open-drain mode, which subsumes the I2C open-drain tristate.
- LED driver with global PWM brightness.

All pad-facing outputs are registered, so the board top only instantiates tristate buffers.

## Interface
Parameters:
- `NUM_BTN`, 6, number of button inputs
- `NUM_GPIO`, 2, number of bidirectional GPIO pads
- `NUM_LED`, 8, number of LED outputs
- `SYNC_STAGES`, 2, synchroniser depth (legal range 2..4)
- `DEBOUNCE_CYCLES`, 250000, cycles of stable input required to accept a change (≥1)
- `BTN_ACTIVE_LOW`, 0, when 1, raw button inputs are inverted before conditioning

Ports:
- `sys_clk`  in  1  system clock. Single clock domain.
- `sys_rst`  in  1  reset. Synchronous, active-high.
- `btn_i`  in  NUM_BTN  raw asynchronous button pads
- `btn_level_o`  out  NUM_BTN  debounced level
- `btn_rise_o` / `btn_fall_o`  out  NUM_BTN  single-cycle edge pulses of the debounced level
- `btn_event_o`  out  NUM_BTN  sticky rise flags
- `btn_event_clr_i`  in  NUM_BTN  per-bit clear of the sticky flags
- `gpio_out_i`  in  NUM_GPIO  output value from the SoC
- `gpio_dir_i`  in  NUM_GPIO  1 = drive
- `gpio_od_i`  in  NUM_GPIO  1 = open-drain mode
- `gpio_in_o`  out  NUM_GPIO  synchronised pad value
- `gpio_pad_i`  in  NUM_GPIO  pad input
- `gpio_pad_o`  out  NUM_GPIO  pad output value
- `gpio_pad_oe`  out  NUM_GPIO  pad output enable
- `led_val_i`  in  NUM_LED  LED on/off request
- `led_duty_i`  in  8  global brightness
- `led_o`  out  NUM_LED  LED pads

## Operation
- **Reset:** all outputs are 0. This covers level, rise, fall, event, `gpio_in_o`, `gpio_pad_o`, `gpio_pad_oe` and `led_o`. Synchronisers, debounce counters and the PWM counter are also cleared.
- **Button path:**
  - Raw input is XORed with `BTN_ACTIVE_LOW`, then passes through a `SYNC_STAGES`-deep flop chain.
  - Per channel, a counter of width `$clog2(DEBOUNCE_CYCLES+1)` runs.
  - While the synced value equals the stable level, the counter holds 0.
  - While the synced value differs, the counter increments each cycle.
  - When the counter would reach `DEBOUNCE_CYCLES`, the level toggles and the counter returns to 0.
  - A glitch shorter than `DEBOUNCE_CYCLES` resets the count to 0 and causes no level change.
  - Rise/fall pulses are asserted for exactly the one cycle in which `btn_level_o` takes its new value.
- **Sticky events:**
  - `btn_event_o[i]` is set by `btn_rise_o[i]` and cleared by `btn_event_clr_i[i]`.
  - If set and clear occur in the same cycle, set wins.
- **GPIO:**
  - Push-pull (`od`=0): pad_o = out, oe = dir.
  - Open-drain (`od`=1): pad_o = 0, oe = dir & ~out.
  - The pad outputs are registered.
  - `gpio_in_o` is the pad value through a `SYNC_STAGES` synchroniser.
  - `gpio_in_o` reflects the pad even while the pin is driven, which gives readback.
- **LED PWM:**
  - An 8-bit free-running counter `pwm_cnt` wraps 255→0.
  - Each LED's on-condition is `led_val_i[i]` AND (`pwm_cnt < led_duty_i`), or `led_val_i[i]` AND (`led_duty_i == 8'hFF`).
  - Duty 0 gives always off.
  - Duty 0xFF is forced to 100% on, not 255/256.
  - `led_o` is registered.

## Timing
- **Button latency:** a change on `btn_i` first sampled at edge 0 and held steady appears on `btn_level_o` after `SYNC_STAGES + DEBOUNCE_CYCLES` edges, together with its rise/fall pulse.
- **Sticky flag:** `btn_event_o` rises 1 cycle after `btn_rise_o`. A clear takes effect on the next edge.
- **GPIO outputs:** `gpio_out_i`/`gpio_dir_i`/`gpio_od_i` reach `gpio_pad_o`/`gpio_pad_oe` with 1 cycle latency.
- **GPIO input:** `gpio_pad_i` reaches `gpio_in_o` with `SYNC_STAGES` cycles latency.
- **LED:** `led_o` lags the combinational compare by 1 cycle. PWM period is 256 cycles.
- **Reset mid-operation:** reset overrides everything on the next edge. A debounce in progress is discarded. After reset, a button held pressed produces a rise after the full latency, because the stable level restarts at 0.

## Structure
- **`board_io_pkg`:**
  - `PWM_W = 8`
  - `typedef enum logic {GPIO_PUSH_PULL, GPIO_OPEN_DRAIN} gpio_mode_t`
  - a `debounce_cnt_w(cycles)` function
- **`io_debounce`** sub-module: one channel, containing the synchroniser, counter, level register and rise/fall outputs. It is instantiated `NUM_BTN` times via generate.
- **In the top of `board_io_ctrl`:** the GPIO and PWM logic, plus the sticky flags.

## Test plan
- **Clean press:** `DEBOUNCE_CYCLES=4`, `SYNC_STAGES=2`. Raise `btn_i[0]` and hold → `btn_level_o[0]`=1 and a 1-cycle `btn_rise_o[0]` exactly 6 edges later. `btn_event_o[0]`=1 on the following cycle.
- **Glitch rejection:** `DEBOUNCE_CYCLES=4`. Apply a 3-cycle pulse on `btn_i[1]` → level, rise and event never assert. A following 5-cycle pulse → rise, then fall after release+6.
- **Sticky set vs clear:** assert `btn_event_clr_i[0]` in the same cycle as `btn_rise_o[0]` → flag stays 1. Clear alone in the next cycle → 0 on the next edge.
- **GPIO modes:**
  - dir=1, od=0, out=1 → pad_o=1, oe=1 after 1 cycle.
  - od=1, out=1 → oe=0.
  - od=1, out=0 → pad_o=0, oe=1.
  - Drive the pad externally low while oe=0 → `gpio_in_o`=0 after 2 cycles.
- **PWM:** `led_val_i`=8'h01.
  - duty=64 → 64 high cycles per 256-cycle period.
  - duty=0 → never high.
  - duty=0xFF → constant high.
  - `led_o[7:1]` stay 0 throughout.
- **Reset mid-debounce:** assert `sys_rst` for 1 cycle partway through a press → all outputs 0. A held button produces a rise a full `SYNC_STAGES+DEBOUNCE_CYCLES` edges after release of reset.
